seq_bit_serializer: RTL and testbench
=====================================

// Module: seq_bit_serializer
// PURPOSE
//   Upstream feeder for the serial sequence-detector FSM. Accepts DATA_W-bit words over a
//   valid/ready handshake into a small FIFO and shifts each word out one bit per clock on seq_out.
//   Back-to-back words produce a gap-free bit stream. When no data is queued, seq_out holds IDLE_BIT.
// PARAMETERS
//   DATA_W      8   word width in bits (>=2)
//   FIFO_DEPTH  4   words of buffering (power of 2, >=2)
//   MSB_FIRST   1   1: bit DATA_W-1 is shifted first; 0: bit 0 is shifted first
//   IDLE_BIT    0   seq_out level when no word is being shifted
// PORTS
//   clk         in   1                  clock, all logic on rising edge
//   rst_n       in   1                  asynchronous, active-low reset
//   in_valid    in   1                  upstream word valid
//   in_ready    out  1                  FIFO can accept (combinational: !full && !flush)
//   in_data     in   DATA_W             upstream word
//   en          in   1                  permit starting a new word from the FIFO
//   flush       in   1                  sync clear of FIFO and shifter
//   seq_out     out  1                  serial bit to detector seq_in (registered)
//   bit_valid   out  1                  seq_out carries a data bit this cycle (registered)
//   busy        out  1                  shifting, or FIFO non-empty
//   fifo_level  out  $clog2(DEPTH)+1    words held in the FIFO, 0..FIFO_DEPTH
// BEHAVIOUR
//   Reset (async, rst_n=0): FIFO empty, fifo_level=0, seq_out=IDLE_BIT, bit_valid=0, busy=0, FSM=IDLE.
//     in_ready=1 once rst_n=1. Reset mid-word discards the word and all queued words.
//   Push: in_valid && in_ready at an edge writes in_data. in_ready=0 when level==FIFO_DEPTH.
//     No bypass: a full FIFO does not accept, even when a pop occurs in the same cycle.
//   Simultaneous push and pop with the FIFO not full: level unchanged, both take effect.
//   FSM IDLE: if en && level>0 at an edge: pop, load shift reg, seq_out<=first bit,
//     bit_valid<=1, bit_cnt<=0, go to SHIFT. Otherwise seq_out<=IDLE_BIT and bit_valid<=0.
//   FSM SHIFT: each edge drives the next bit and increments bit_cnt. At the edge after the last bit
//     (bit_cnt==DATA_W-1):
//     if en && level>0: pop the next word and present its first bit, so there is no idle cycle.
//     else go to IDLE, with seq_out<=IDLE_BIT and bit_valid<=0.
//   Latency: word pushed into an empty FIFO at edge E (en=1) -> first bit on seq_out after E+1.
//     Word occupies exactly DATA_W consecutive cycles.
//   en=0 mid-word: the current word always completes. en only gates starting the next pop.
//   flush=1 at an edge: FIFO emptied, shifter aborted, FSM=IDLE, seq_out<=IDLE_BIT, bit_valid<=0.
//     in_ready=0 while flush=1, so a same-cycle push is not accepted. flush has priority over pop.
//   busy = (FSM==SHIFT) || (level!=0). It is combinational from registered state.
//   bit_cnt width is $clog2(DATA_W). It never wraps past DATA_W-1.
// TESTING
//   1 MSB_FIRST=1, en=1, push 8'h5A into empty FIFO -> seq_out 0,1,0,1,1,0,1,0 with bit_valid=1 for
//     8 cycles, then IDLE_BIT. The downstream detector asserts its flag on the 8th bit.
//   2 Push 8'hFF,8'h00,8'hA5 on consecutive cycles -> 24 contiguous bit_valid=1 cycles, no gap,
//     correct bit order, fifo_level peaks at 2.
//   3 en=0, push 5 words -> 4 accepted, fifo_level=4, in_ready=0, 5th held by upstream.
//     Then en=1 -> drain in order, and in_ready returns to 1 after the first pop.
//   4 en dropped during bit 3 of a word, one word queued -> current word finishes all 8 bits,
//     then bit_valid=0, fifo_level stays 1, busy=1.
//   5 flush during bit 4 with 2 queued and in_valid=1 -> next cycle: bit_valid=0, seq_out=IDLE_BIT,
//     fifo_level=0, push not taken.
//   6 rst_n low mid-word (async, between edges) -> outputs reset immediately. After release,
//     a push of 8'h5A replays exactly as in test 1.

Source files
------------

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer: buffers DATA_W-bit words in a small FIFO and shifts each one
// out on seq_out, one bit per clock, back-to-back with no gap between words.
module seq_bit_serializer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_BIT   = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          en,
  input  logic                          flush,
  output logic                          seq_out,
  output logic                          bit_valid,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] head_word;
  logic [DATA_W-1:0] shift_reg;
  logic [CW-1:0]     bit_cnt;
  logic              push;
  logic              pop;
  logic              word_done;

  // A full FIFO refuses pushes even when a pop happens in the same cycle (no bypass path).
  assign in_ready  = (fifo_level != FULL_LVL) && !flush;
  assign push      = in_valid && in_ready;
  assign word_done = (state == IDLE) || (bit_cnt == LAST_BIT);
  assign pop       = !flush && en && (fifo_level != '0) && word_done;
  assign head_word = mem[rd_ptr];
  assign busy      = (state == SHIFT) || (fifo_level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // shift_reg holds the bits still to be sent, with the next one already at the exit end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      seq_out   <= IDLE_BIT;
      bit_valid <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (flush) begin
      state     <= IDLE;
      seq_out   <= IDLE_BIT;
      bit_valid <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (pop) begin
      state     <= SHIFT;
      bit_valid <= 1'b1;
      bit_cnt   <= '0;
      if (MSB_FIRST) begin
        seq_out   <= head_word[DATA_W-1];
        shift_reg <= head_word << 1;
      end else begin
        seq_out   <= head_word[0];
        shift_reg <= head_word >> 1;
      end
    end else if (!word_done) begin
      bit_cnt <= bit_cnt + 1'b1;
      if (MSB_FIRST) begin
        seq_out   <= shift_reg[DATA_W-1];
        shift_reg <= shift_reg << 1;
      end else begin
        seq_out   <= shift_reg[0];
        shift_reg <= shift_reg >> 1;
      end
    end else begin
      state     <= IDLE;
      seq_out   <= IDLE_BIT;
      bit_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: directed scenarios plus random traffic,
// compared every cycle against a queue-of-words / queue-of-bits reference model.
module tb_seq_bit_serializer;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam bit MSB_FIRST  = 1'b1;
  localparam bit IDLE_BIT   = 1'b0;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              en;
  logic              flush;
  logic              seq_out;
  logic              bit_valid;
  logic              busy;
  logic [2:0]        fifo_level;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mdl_fifo[$];
  bit                mdl_bits[$];
  logic              exp_out;
  logic              exp_valid;

  seq_bit_serializer #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MSB_FIRST(MSB_FIRST), .IDLE_BIT(IDLE_BIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .en(en), .flush(flush), .seq_out(seq_out), .bit_valid(bit_valid), .busy(busy),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mdl_fifo.delete();
    mdl_bits.delete();
    exp_out   = IDLE_BIT;
    exp_valid = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic bit modelStep(input logic v, input logic [DATA_W-1:0] d,
                                   input logic e, input logic f);
    bit rdy = (mdl_fifo.size() < FIFO_DEPTH) && !f;
    logic [DATA_W-1:0] w;
    if (f) begin
      modelReset();
      return 1'b0;
    end
    if (mdl_bits.size() > 0) begin
      exp_out   = mdl_bits.pop_front();
      exp_valid = 1'b1;
    end else if (e && mdl_fifo.size() > 0) begin
      w = mdl_fifo.pop_front();
      for (int i = 0; i < DATA_W; i++)
        mdl_bits.push_back(MSB_FIRST ? w[DATA_W-1-i] : w[i]);
      exp_out   = mdl_bits.pop_front();
      exp_valid = 1'b1;
    end else begin
      exp_out   = IDLE_BIT;
      exp_valid = 1'b0;
    end
    if (v && rdy) mdl_fifo.push_back(d);
    return v && rdy;
  endfunction

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic e,
                               input logic f, output bit taken);
    in_valid = v;
    in_data  = d;
    en       = e;
    flush    = f;
    #1;
    checkOutput("in_ready", {31'd0, in_ready},
                {31'd0, (mdl_fifo.size() < FIFO_DEPTH) && !f});
    @(posedge clk);
    taken = modelStep(v, d, e, f);
    #1;
    checkOutput("seq_out",    {31'd0, seq_out},   {31'd0, exp_out});
    checkOutput("bit_valid",  {31'd0, bit_valid}, {31'd0, exp_valid});
    checkOutput("busy",       {31'd0, busy},      {31'd0, exp_valid || (mdl_fifo.size() != 0)});
    checkOutput("fifo_level", {29'd0, fifo_level}, mdl_fifo.size());
  endtask

  task automatic idleCycles(input int n);
    bit t;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, t);
  endtask

  task automatic runTest1();
    bit t;
    logic [7:0] got;
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, t);
    checkOutput("t1_taken", {31'd0, t}, 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, t);
    got = {7'd0, seq_out};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, t);
      checkOutput("t1_valid", {31'd0, bit_valid}, 32'd1);
      got = {got[6:0], seq_out};
    end
    checkOutput("t1_word", {24'd0, got}, 32'h5A);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, t);
    checkOutput("t1_idle_valid", {31'd0, bit_valid}, 32'd0);
    checkOutput("t1_idle_out",   {31'd0, seq_out},   {31'd0, IDLE_BIT});
  endtask

  initial begin
    bit t;
    int vcnt, run, maxrun, peak, idx, wi, nb;
    logic [7:0] words [5];
    logic [7:0] acc;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; en = 1'b0; flush = 1'b0;
    modelReset();
    #3;
    checkOutput("rst_seq_out",   {31'd0, seq_out},   {31'd0, IDLE_BIT});
    checkOutput("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
    checkOutput("rst_busy",      {31'd0, busy},      32'd0);
    checkOutput("rst_level",     {29'd0, fifo_level}, 32'd0);
    #9 rst_n = 1'b1;
    #1 checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] test 1: single word 5A");
    runTest1();
    idleCycles(2);

    $display("[TB] test 2: back-to-back words");
    vcnt = 0; run = 0; maxrun = 0; peak = 0;
    for (int i = 0; i < 33; i++) begin
      case (i)
        0: applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, t);
        1: applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, t);
        2: applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, t);
        default: applyStimulus(1'b0, '0, 1'b1, 1'b0, t);
      endcase
      if (bit_valid) begin vcnt++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    checkOutput("t2_valid_cycles", vcnt, 32'd24);
    checkOutput("t2_max_run",      maxrun, 32'd24);
    checkOutput("t2_level_peak",   peak, 32'd2);

    $display("[TB] test 3: fill with en=0 then drain");
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h3C; words[3] = 8'h81; words[4] = 8'hE7;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, words[idx], 1'b0, 1'b0, t);
      if (t) idx++;
    end
    checkOutput("t3_accepted", idx, 32'd4);
    checkOutput("t3_level",    {29'd0, fifo_level}, 32'd4);
    checkOutput("t3_ready_full", {31'd0, in_ready}, 32'd0);
    wi = 0; nb = 0; acc = '0;
    applyStimulus(1'b1, words[idx], 1'b1, 1'b0, t);
    checkOutput("t3_ready_after_pop", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 60; i++) begin
      if (bit_valid) begin
        acc = {acc[6:0], seq_out};
        nb++;
        if (nb == 8) begin
          checkOutput("t3_word", {24'd0, acc}, {24'd0, words[wi]});
          wi++; nb = 0;
        end
      end
      if (idx < 5) begin
        applyStimulus(1'b1, words[idx], 1'b1, 1'b0, t);
        if (t) idx++;
      end else applyStimulus(1'b0, '0, 1'b1, 1'b0, t);
    end
    checkOutput("t3_words_out", wi, 32'd5);

    $display("[TB] test 4: en dropped mid-word");
    applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0, t);
    applyStimulus(1'b1, 8'h96, 1'b1, 1'b0, t);
    vcnt = int'(bit_valid);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, t);
      vcnt += int'(bit_valid);
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, t);
      vcnt += int'(bit_valid);
    end
    checkOutput("t4_valid_cycles", vcnt, 32'd8);
    checkOutput("t4_bit_valid",    {31'd0, bit_valid}, 32'd0);
    checkOutput("t4_level",        {29'd0, fifo_level}, 32'd1);
    checkOutput("t4_busy",         {31'd0, busy}, 32'd1);
    idleCycles(12);

    $display("[TB] test 5: flush mid-word");
    applyStimulus(1'b1, 8'hA1, 1'b1, 1'b0, t);
    applyStimulus(1'b1, 8'hB2, 1'b1, 1'b0, t);
    applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0, t);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, t);
    checkOutput("t5_level_before", {29'd0, fifo_level}, 32'd2);
    applyStimulus(1'b1, 8'hD4, 1'b1, 1'b1, t);
    checkOutput("t5_bit_valid", {31'd0, bit_valid}, 32'd0);
    checkOutput("t5_seq_out",   {31'd0, seq_out},   {31'd0, IDLE_BIT});
    checkOutput("t5_level",     {29'd0, fifo_level}, 32'd0);
    idleCycles(2);

    $display("[TB] test 6: async reset mid-word");
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, t);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, t);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, t);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("t6_bit_valid", {31'd0, bit_valid}, 32'd0);
    checkOutput("t6_seq_out",   {31'd0, seq_out},   {31'd0, IDLE_BIT});
    checkOutput("t6_busy",      {31'd0, busy},      32'd0);
    checkOutput("t6_level",     {29'd0, fifo_level}, 32'd0);
    #2 rst_n = 1'b1;
    runTest1();

    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 40) == 0), t);
    idleCycles(45);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
